// File: rtl/mul_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_pipe_pkg : shared opcodes and CSA stage-partitioning helpers    |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
package mul_pipe_pkg;

  localparam int MUL_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL_OP_MUL  = 2'b00,
    MUL_OP_MADD = 2'b01,
    MUL_OP_MSUB = 2'b10,
    MUL_OP_RSVD = 2'b11
  } mul_op_e;

  // Partial-product rows are split evenly over the LATENCY-1 tree stages;
  // with LATENCY=1 the single combinational stage takes every row.
  function automatic int csa_rows_per_stage(input int width, input int latency);
    int groups;
    groups = (latency > 1) ? latency - 1 : 1;
    return (width + groups - 1) / groups;
  endfunction

  function automatic int csa_rows_in_stage(input int width, input int latency, input int stage);
    int per;
    int rem;
    per = csa_rows_per_stage(width, latency);
    rem = width - stage * per;
    if (rem > per) rem = per;
    if (rem < 0)   rem = 0;
    return rem;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_csa_tree.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_csa_tree : partial products for rows ROW_LO..ROW_LO+ROW_CNT-1   |
// |                folded into a running sum/carry pair with 3:2 CSAs   |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module mul_csa_tree
  import mul_pipe_pkg::*;
#(
  parameter int WIDTH   = MUL_DEFAULT_WIDTH,
  parameter int ROW_LO  = 0,
  parameter int ROW_CNT = WIDTH
) (
  input  logic [2*WIDTH-1:0] a_ext,
  input  logic [ROW_CNT-1:0] b_bits,
  input  logic [ROW_CNT-1:0] row_neg,
  input  logic [2*WIDTH-1:0] in_sum,
  input  logic [2*WIDTH-1:0] in_carry,
  output logic [2*WIDTH-1:0] out_sum,
  output logic [2*WIDTH-1:0] out_carry
);

  localparam int PW = 2 * WIDTH;

  for (genvar i = 0; i < ROW_CNT; i++) begin : g_row
    logic [PW-1:0] shifted;
    logic [PW-1:0] pp;
    logic [PW-1:0] s_in;
    logic [PW-1:0] c_in;
    logic [PW-1:0] s_out;
    logic [PW-1:0] c_out;

    // A negated row is one's complement here; its +1 enters as the initial carry.
    assign shifted = a_ext << (ROW_LO + i);
    assign pp      = b_bits[i] ? (row_neg[i] ? ~shifted : shifted) : '0;

    if (i == 0) begin : g_first
      assign s_in = in_sum;
      assign c_in = in_carry;
    end else begin : g_chain
      assign s_in = g_row[i-1].s_out;
      assign c_in = g_row[i-1].c_out;
    end

    assign s_out = s_in ^ c_in ^ pp;
    assign c_out = ((s_in & c_in) | (s_in & pp) | (c_in & pp)) << 1;
  end

  assign out_sum   = g_row[ROW_CNT-1].s_out;
  assign out_carry = g_row[ROW_CNT-1].c_out;

endmodule
`default_nettype wire

// File: rtl/mul_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_pipe : pipelined MUL/MADD/MSUB with valid/ready, flush and tag  |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module mul_pipe
  import mul_pipe_pkg::*;
#(
  parameter int WIDTH   = MUL_DEFAULT_WIDTH,
  parameter int LATENCY = 3,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [1:0]         in_op,
  input  logic [2*WIDTH-1:0] in_acc,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW   = 2 * WIDTH;
  localparam int ROWS = csa_rows_per_stage(WIDTH, LATENCY);

  logic               stall;
  logic               advance;
  logic [LATENCY-1:0] r_vld;
  logic [PW-1:0]      in_aext;
  logic [PW-1:0]      in_carry0;
  logic [PW-1:0]      fin_sum;
  logic [PW-1:0]      fin_carry;
  logic [PW-1:0]      fin_acc;
  logic [1:0]         fin_op;
  logic [TAG_W-1:0]   fin_tag;
  logic [PW-1:0]      prod;
  logic [PW-1:0]      result_d;

  assign stall     = out_valid & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = ~stall;
  assign out_valid = r_vld[LATENCY-1];

  // Signed mode: top multiplier row has weight -2^(WIDTH-1), so it is negated.
  assign in_aext   = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
  assign in_carry0 = PW'(in_signed & in_b[WIDTH-1]);

  if (LATENCY == 1) begin : g_comb
    logic [WIDTH-1:0] neg;

    for (genvar i = 0; i < WIDTH; i++) begin : g_neg
      assign neg[i] = (i == WIDTH - 1) ? in_signed : 1'b0;
    end

    mul_csa_tree #(
      .WIDTH   (WIDTH),
      .ROW_LO  (0),
      .ROW_CNT (WIDTH)
    ) u_tree (
      .a_ext     (in_aext),
      .b_bits    (in_b),
      .row_neg   (neg),
      .in_sum    ('0),
      .in_carry  (in_carry0),
      .out_sum   (fin_sum),
      .out_carry (fin_carry)
    );

    assign fin_op  = in_op;
    assign fin_acc = in_acc;
    assign fin_tag = in_tag;
  end else begin : g_pipe
    for (genvar k = 0; k < LATENCY - 1; k++) begin : g_stage
      localparam int LO   = k * ROWS;
      localparam int CNT  = csa_rows_in_stage(WIDTH, LATENCY, k);
      localparam bit LAST = (k == LATENCY - 2);

      logic [PW-1:0]       src_aext;
      logic [WIDTH-LO-1:0] src_b;
      logic                src_sgn;
      logic [1:0]          src_op;
      logic [PW-1:0]       src_acc;
      logic [TAG_W-1:0]    src_tag;
      logic [PW-1:0]       src_sum;
      logic [PW-1:0]       src_carry;
      logic [CNT-1:0]      neg;
      logic [PW-1:0]       nxt_sum;
      logic [PW-1:0]       nxt_carry;
      logic [PW-1:0]       r_sum;
      logic [PW-1:0]       r_carry;
      logic [PW-1:0]       r_acc;
      logic [1:0]          r_op;
      logic [TAG_W-1:0]    r_tag;

      if (k == 0) begin : g_src_in
        assign src_aext  = in_aext;
        assign src_b     = in_b;
        assign src_sgn   = in_signed;
        assign src_op    = in_op;
        assign src_acc   = in_acc;
        assign src_tag   = in_tag;
        assign src_sum   = '0;
        assign src_carry = in_carry0;
      end else begin : g_src_reg
        assign src_aext  = g_stage[k-1].g_fwd.r_aext;
        assign src_b     = g_stage[k-1].g_fwd.r_b;
        assign src_sgn   = g_stage[k-1].g_fwd.r_sgn;
        assign src_op    = g_stage[k-1].r_op;
        assign src_acc   = g_stage[k-1].r_acc;
        assign src_tag   = g_stage[k-1].r_tag;
        assign src_sum   = g_stage[k-1].r_sum;
        assign src_carry = g_stage[k-1].r_carry;
      end

      for (genvar i = 0; i < CNT; i++) begin : g_neg
        assign neg[i] = (LO + i == WIDTH - 1) ? src_sgn : 1'b0;
      end

      mul_csa_tree #(
        .WIDTH   (WIDTH),
        .ROW_LO  (LO),
        .ROW_CNT (CNT)
      ) u_tree (
        .a_ext     (src_aext),
        .b_bits    (src_b[CNT-1:0]),
        .row_neg   (neg),
        .in_sum    (src_sum),
        .in_carry  (src_carry),
        .out_sum   (nxt_sum),
        .out_carry (nxt_carry)
      );

      always_ff @(posedge clk) begin
        if (advance) begin
          r_sum   <= nxt_sum;
          r_carry <= nxt_carry;
          r_acc   <= src_acc;
          r_op    <= src_op;
          r_tag   <= src_tag;
        end
      end

      // Only stages that still have rows downstream forward the operands.
      if (!LAST) begin : g_fwd
        logic [PW-1:0]           r_aext;
        logic [WIDTH-LO-CNT-1:0] r_b;
        logic                    r_sgn;

        always_ff @(posedge clk) begin
          if (advance) begin
            r_aext <= src_aext;
            r_b    <= src_b[WIDTH-LO-1:CNT];
            r_sgn  <= src_sgn;
          end
        end
      end
    end

    assign fin_sum   = g_stage[LATENCY-2].r_sum;
    assign fin_carry = g_stage[LATENCY-2].r_carry;
    assign fin_acc   = g_stage[LATENCY-2].r_acc;
    assign fin_op    = g_stage[LATENCY-2].r_op;
    assign fin_tag   = g_stage[LATENCY-2].r_tag;
  end

  always_comb begin
    prod = fin_sum + fin_carry;
    case (fin_op)
      MUL_OP_MADD: result_d = fin_acc + prod;
      MUL_OP_MSUB: result_d = fin_acc - prod;
      default:     result_d = prod;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vld <= '0;
    end else if (flush) begin
      r_vld <= '0;
    end else if (advance) begin
      r_vld <= (r_vld << 1) | LATENCY'(in_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (advance) begin
      out_result <= result_d;
      out_tag    <= fin_tag;
    end
  end

endmodule
`default_nettype wire

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
- Parametrised, fully pipelined integer multiply / multiply-accumulate unit for the execute stage.
- Successor to the fixed 32-bit, fixed-latency multiplier.
- Adds generic operand width, configurable latency, valid/ready handshake with backpressure, pipeline flush, a tag carried through the pipe, and MADD/MSUB accumulate modes for the HI/LO path.
- Accepts one operation per cycle when not stalled.

Parameters:
WIDTH, 32, operand width in bits; product and accumulator are 2*WIDTH.
LATENCY, 3, cycles from input acceptance to result valid; legal range 1..4.
TAG_W, 5, width of the opaque tag (e.g. destination/ROB id) passed through unchanged.

Ports:
clk  in  1  clock, all state updates on rising edge.
resetn  in  1  synchronous active-low reset.
flush  in  1  kill all in-flight operations.
in_valid  in  1  operation presented.
in_ready  out  1  unit can accept this cycle.
in_a  in  WIDTH  multiplicand.
in_b  in  WIDTH  multiplier.
in_signed  in  1  1 = both operands two's-complement (MULT); 0 = unsigned (MULTU).
in_op  in  2  00 MUL, 01 MADD, 10 MSUB, 11 treated as MUL.
in_acc  in  2*WIDTH  accumulator ({HI,LO}); used only by MADD/MSUB.
in_tag  in  TAG_W  tag.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts result.
out_result  out  2*WIDTH  final result.
out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - all stage valid bits cleared;
  - out_valid=0, out_result=0, out_tag=0.
  - A reset mid-operation discards everything in flight.
- Stall condition: stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - The whole pipe holds when stalled; no bubble collapsing is required.
- Accept: an operation is accepted when in_valid & in_ready.
  - in_a, in_b, in_signed, in_op, in_acc and in_tag are captured together.
  - Inputs are not sampled again after acceptance.
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+LATENCY-1, assuming no stalls.
  - Each stall cycle adds exactly one cycle.
  - Throughput is 1 op/cycle.
- Ordering: results leave strictly in acceptance order. The tag is never altered.
- Output hold: out_result and out_tag hold stable while out_valid & ~out_ready.
- Product:
  - signed: P = sext(a) * sext(b).
  - unsigned: P = zext(a) * zext(b).
  - Computed exactly in 2*WIDTH bits.
- Final result:
  - MUL: P.
  - MADD: in_acc + P.
  - MSUB: in_acc - P.
  - All arithmetic is modulo 2^(2*WIDTH); overflow is silently wrapped and no flag is raised.
- Pipeline split:
  - partial-product generation and carry-save reduction are spread over stages 1..LATENCY-1;
  - the final carry-propagate add and the accumulate are in the last stage.
  - With LATENCY=1 the whole operation is computed in one cycle.
- Flush:
  - a flush sampled at an edge clears every stage valid bit and out_valid at that edge;
  - an input handshake in the same cycle is discarded;
  - flush overrides stall;
  - datapath registers may keep stale data, but out_valid must be 0 on the following cycle.
- Simultaneous events:
  - with out_valid & out_ready & in_valid, the output retires and the new op enters in the same cycle;
  - reset has priority over flush, and flush over accept.
- Edge operands must produce exact results:
  - most-negative × most-negative (signed);
  - all-ones × all-ones (unsigned).
- in_op=11 behaves exactly as MUL.

Decomposition:
- Shared package: MUL_OP_MUL/MADD/MSUB encodings, default WIDTH, and a localparam function computing the per-stage CSA row count from WIDTH and LATENCY.
- One sub-module, mul_csa_tree: combinational partial-product generation and 3:2 reduction of WIDTH signed/unsigned rows to a sum/carry pair.
- mul_pipe inserts registers between tree levels according to LATENCY and owns the handshake, valid shift chain, tag chain, flush and final add/accumulate.

Test Plan:
- WIDTH=32, LATENCY=3, in_signed=1, MUL, a=0xFFFFFFFF, b=0x00000002, tag=7 → out_valid 3 cycles later, out_result=0xFFFFFFFF_FFFFFFFE, out_tag=7.
- Unsigned MUL a=b=0xFFFFFFFF → 0xFFFFFFFE_00000001; signed MUL a=b=0x80000000 → 0x40000000_00000000.
- MADD, signed, acc=0x00000000_00000010, a=3, b=5 → 0x1F. MSUB, same operands → 0x1. MSUB unsigned, acc=0, a=1, b=1 → 0xFFFFFFFF_FFFFFFFF.
- Back-to-back stream of 6 ops with out_ready held low 4 cycles after the first result → in_ready=0 during the stall, outputs stable, all 6 results emitted in order with correct tags, no loss or duplicate.
- Three ops in flight, flush asserted for one cycle together with in_valid → out_valid stays 0 for the next LATENCY cycles; the next op accepted after the flush returns a correct result.
- resetn=0 for one cycle mid-stream → out_valid=0, out_result=0, out_tag=0 after the edge; the pipe accepts new work immediately once resetn=1.
